// File: rtl/sad_column_scheduler.sv
// rtl/sad_column_scheduler.sv - column FIFO and one-in-flight issue sequencer for the SAD engine; optional watchdog via SAD_SCHED_WATCHDOG_EN
module sad_column_scheduler #(
  parameter int KERNEL_WIDTH = 3,
  parameter int OFFSET       = 10,
  parameter int PRIME_COLS   = KERNEL_WIDTH + OFFSET,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          col_valid_in,
  input  logic [KERNEL_WIDTH*8-1:0]     left_col_in,
  input  logic [KERNEL_WIDTH*8-1:0]     right_col_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  output logic                          sad_valid_out,
  output logic [KERNEL_WIDTH*8-1:0]     sad_left_out,
  output logic [KERNEL_WIDTH*8-1:0]     sad_right_out,
  output logic [10:0]                   sad_hcount_out,
  output logic [9:0]                    sad_vcount_out,
  input  logic                          sad_busy_in,
  input  logic                          sad_valid_in,
  input  logic [7:0]                    sad_depth_in,
  input  logic [9:0]                    sad_hcount_in,
  input  logic [8:0]                    sad_vcount_in,
  output logic                          depth_valid_out,
  output logic [7:0]                    depth_out,
  output logic [9:0]                    depth_hcount_out,
  output logic [8:0]                    depth_vcount_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic [15:0]                   drop_count_out,
  output logic                          timeout_out
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = KERNEL_WIDTH * 8;
  localparam int EW   = 2 * CW + 11 + 10 + 1;
  localparam int PW   = $clog2(PRIME_COLS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [EW-1:0]  head;
  logic [CW-1:0]  head_left;
  logic [CW-1:0]  head_right;
  logic [10:0]    head_h;
  logic [9:0]     head_v;
  logic           head_row_start;
  logic           full;
  logic           empty;
  logic           pop;
  logic           push;
  logic           drop;
  logic [PW-1:0]  prime_cnt;
  logic [PW-1:0]  prime_next;
  logic           primed;
  logic           wd_expire;

  assign head           = mem[rd_ptr];
  assign head_left      = head[EW-1 -: CW];
  assign head_right     = head[EW-1-CW -: CW];
  assign head_h         = head[21:11];
  assign head_v         = head[10:1];
  assign head_row_start = head[0];

  assign empty = (fifo_count_out == '0);
  assign full  = (fifo_count_out == CNTW'(FIFO_DEPTH));
  // A pop frees a slot in the same cycle, so a push to a full FIFO still lands when paired with a pop
  assign pop   = (state == IDLE) && !empty && !sad_busy_in;
  assign push  = col_valid_in && (!full || pop);
  assign drop  = col_valid_in && full && !pop;

  // Row start restarts the priming count; otherwise it climbs and holds at the last priming column
  always_comb begin
    prime_next = prime_cnt;
    if (head_row_start)
      prime_next = '0;
    else if (prime_cnt != PW'(PRIME_COLS - 1))
      prime_next = prime_cnt + PW'(1);
  end

  // Column storage; written only on an accepted push
  always_ff @(posedge clk_in) begin
    if (push)
      mem[wr_ptr] <= {left_col_in, right_col_in, hcount_in, vcount_in, (hcount_in == 11'd0)};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_count_out <= fifo_count_out + CNTW'(1);
      else if (pop && !push)
        fifo_count_out <= fifo_count_out - CNTW'(1);
    end
  end

  // Saturating count of columns lost to a full FIFO
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      drop_count_out <= '0;
    else if (drop && (drop_count_out != 16'hFFFF))
      drop_count_out <= drop_count_out + 16'd1;
  end

`ifdef SAD_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  assign wd_expire = (state == WAIT) && (wd_cnt == WW'(TIMEOUT - 1));

  // Count cycles spent waiting for a result; the flag stays set until reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wd_cnt      <= '0;
      timeout_out <= 1'b0;
    end else begin
      if (state == WAIT) wd_cnt <= wd_cnt + WW'(1);
      else               wd_cnt <= '0;
      if (wd_expire && !sad_valid_in) timeout_out <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // Issue sequencer: pop, strobe the engine once, then wait for its result before the next column
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      sad_valid_out    <= 1'b0;
      sad_left_out     <= '0;
      sad_right_out    <= '0;
      sad_hcount_out   <= '0;
      sad_vcount_out   <= '0;
      depth_valid_out  <= 1'b0;
      depth_out        <= '0;
      depth_hcount_out <= '0;
      depth_vcount_out <= '0;
      prime_cnt        <= '0;
      primed           <= 1'b0;
    end else begin
      sad_valid_out   <= 1'b0;
      depth_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state          <= ISSUE;
            sad_left_out   <= head_left;
            sad_right_out  <= head_right;
            sad_hcount_out <= head_h;
            sad_vcount_out <= head_v;
            prime_cnt      <= prime_next;
            primed         <= (prime_next == PW'(PRIME_COLS - 1));
          end
        end
        ISSUE: begin
          if (!sad_busy_in) begin
            sad_valid_out <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (sad_valid_in) begin
            state            <= IDLE;
            depth_valid_out  <= primed;
            depth_out        <= sad_depth_in;
            depth_hcount_out <= sad_hcount_in;
            depth_vcount_out <= sad_vcount_in;
          end else if (wd_expire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_column_scheduler.sv
// tb/tb_sad_column_scheduler.sv - directed and randomized checks of sad_column_scheduler against a column-level model
module tb_sad_column_scheduler;

  localparam int KW    = 3;
  localparam int OFF   = 10;
  localparam int PRIME = KW + OFF;
  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in;
  logic          col_valid_in;
  logic [23:0]   left_col_in, right_col_in;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          sad_valid_out;
  logic [23:0]   sad_left_out, sad_right_out;
  logic [10:0]   sad_hcount_out;
  logic [9:0]    sad_vcount_out;
  logic          sad_busy_in;
  logic          sad_valid_in;
  logic [7:0]    sad_depth_in;
  logic [9:0]    sad_hcount_in;
  logic [8:0]    sad_vcount_in;
  logic          depth_valid_out;
  logic [7:0]    depth_out;
  logic [9:0]    depth_hcount_out;
  logic [8:0]    depth_vcount_out;
  logic [3:0]    fifo_count_out;
  logic [15:0]   drop_count_out;
  logic          timeout_out;

  sad_column_scheduler #(
    .KERNEL_WIDTH(KW), .OFFSET(OFF), .PRIME_COLS(PRIME), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .col_valid_in(col_valid_in),
    .left_col_in(left_col_in), .right_col_in(right_col_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .sad_valid_out(sad_valid_out), .sad_left_out(sad_left_out), .sad_right_out(sad_right_out),
    .sad_hcount_out(sad_hcount_out), .sad_vcount_out(sad_vcount_out),
    .sad_busy_in(sad_busy_in), .sad_valid_in(sad_valid_in), .sad_depth_in(sad_depth_in),
    .sad_hcount_in(sad_hcount_in), .sad_vcount_in(sad_vcount_in),
    .depth_valid_out(depth_valid_out), .depth_out(depth_out),
    .depth_hcount_out(depth_hcount_out), .depth_vcount_out(depth_vcount_out),
    .fifo_count_out(fifo_count_out), .drop_count_out(drop_count_out), .timeout_out(timeout_out)
  );

  typedef struct { logic [23:0] l; logic [23:0] r; logic [10:0] h; logic [9:0] v; } col_t;
  typedef struct { logic [7:0] d; logic [9:0] h; logic [8:0] v; } res_t;

  col_t issue_q[$];
  res_t res_q[$];
  int   errors = 0;
  int   checks = 0;
  int   since_row;
  int   eng_mode;
  int   eng_lat;
  int   strobes;
  int   group_strobes;
  bit   check_period;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] depth_fn(input logic [10:0] h, input logic [9:0] v);
    return h[7:0] ^ v[7:0];
  endfunction

  function automatic col_t mk_col(input int h, input int v);
    col_t c;
    c.l = 24'($urandom);
    c.r = 24'($urandom);
    c.h = 11'(h);
    c.v = 10'(v);
    return c;
  endfunction

  // Model: every non-dropped column is issued in order; a result is reported once the row has 13 columns behind it
  task automatic expect_col(input col_t c, input bit with_result);
    res_t r;
    issue_q.push_back(c);
    if (c.h == 11'd0) since_row = 0;
    else if (since_row < PRIME - 1) since_row++;
    if (with_result && since_row == PRIME - 1) begin
      r.d = depth_fn(c.h, c.v);
      r.h = c.h[9:0];
      r.v = c.v[8:0];
      res_q.push_back(r);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_col(input col_t c);
    col_valid_in = 1'b1;
    left_col_in  = c.l;
    right_col_in = c.r;
    hcount_in    = c.h;
    vcount_in    = c.v;
    step();
    col_valid_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobes"}, 64'({sad_valid_out, depth_valid_out, timeout_out}), 64'(0));
    chk({tag, "_issue_data"}, 64'({sad_left_out, sad_right_out}), 64'(0));
    chk({tag, "_issue_pos"}, 64'({sad_hcount_out, sad_vcount_out}), 64'(0));
    chk({tag, "_result"}, 64'({depth_out, depth_hcount_out, depth_vcount_out}), 64'(0));
    chk({tag, "_counts"}, 64'({fifo_count_out, drop_count_out}), 64'(0));
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step();
      if (issue_q.size() == 0 && !sad_busy_in && !sad_valid_in && fifo_count_out == 0 && !sad_valid_out)
        done = 1'b1;
    end
    repeat (3) step();
    chk({tag, "_drained"}, 64'(done), 64'(1));
    chk({tag, "_results_left"}, 64'(res_q.size()), 64'(0));
  endtask

  task automatic wait_strobes(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && strobes < target; i++) step();
    chk(tag, 64'(strobes >= target), 64'(1));
  endtask

  task automatic apply_reset(input string tag);
    rst_in = 1'b0;
    #1;
    check_all_zero(tag);
    step();
    rst_in = 1'b1;
    issue_q.delete();
    res_q.delete();
    since_row = 0;
    step();
  endtask

  // Engine model plus output monitor: checks every issue strobe and result, then answers after eng_lat cycles
  task automatic engine_monitor();
    int   cyc = 0;
    int   last_strobe = 0;
    int   eng_cnt = 0;
    bit   prev_strobe = 1'b0;
    col_t eng_col;
    col_t e;
    res_t r;
    sad_busy_in  = 1'b0;
    sad_valid_in = 1'b0;
    sad_depth_in = '0;
    sad_hcount_in = '0;
    sad_vcount_in = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sad_valid_out) begin
        chk("issue_single_cycle", 64'(prev_strobe), 64'(0));
        chk("issue_while_busy", 64'(sad_busy_in), 64'(0));
        chk("issue_expected", 64'(issue_q.size() > 0), 64'(1));
        if (issue_q.size() > 0) begin
          e = issue_q.pop_front();
          chk("issue_hcount", 64'(sad_hcount_out), 64'(e.h));
          chk("issue_vcount", 64'(sad_vcount_out), 64'(e.v));
          chk("issue_cols", 64'({sad_left_out, sad_right_out}), 64'({e.l, e.r}));
        end
        if (check_period && group_strobes > 0)
          chk("issue_period", 64'(cyc - last_strobe), 64'(OFF + 5));
        group_strobes++;
        strobes++;
        last_strobe = cyc;
      end
      prev_strobe = sad_valid_out;
      if (depth_valid_out) begin
        chk("result_expected", 64'(res_q.size() > 0), 64'(1));
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("result_depth", 64'(depth_out), 64'(r.d));
          chk("result_hcount", 64'(depth_hcount_out), 64'(r.h));
          chk("result_vcount", 64'(depth_vcount_out), 64'(r.v));
        end
      end
      if (sad_valid_in) begin
        sad_valid_in = 1'b0;
        sad_busy_in  = 1'b0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          sad_valid_in  = 1'b1;
          sad_depth_in  = depth_fn(eng_col.h, eng_col.v);
          sad_hcount_in = eng_col.h[9:0];
          sad_vcount_in = eng_col.v[8:0];
        end
      end
      if (sad_valid_out && eng_mode == 0) begin
        sad_busy_in = 1'b1;
        eng_col.h   = sad_hcount_out;
        eng_col.v   = sad_vcount_out;
        eng_cnt     = eng_lat;
      end
    end
  endtask

  initial begin
    col_t c;
    int   s0;
    int   h;
    int   n;
    bit   seen;
    rst_in        = 1'b0;
    col_valid_in  = 1'b0;
    left_col_in   = '0;
    right_col_in  = '0;
    hcount_in     = '0;
    vcount_in     = '0;
    eng_mode      = 0;
    eng_lat       = OFF + 2;
    check_period  = 1'b0;
    since_row     = 0;
    strobes       = 0;
    group_strobes = 0;
    fork
      engine_monitor();
    join_none

    repeat (3) step();
    check_all_zero("reset");
    rst_in = 1'b1;
    step();

    // Single priming column: issue latency and no qualified result
    c = mk_col(0, 5);
    expect_col(c, 1'b1);
    push_col(c);
    chk("single_push_count", 64'(fifo_count_out), 64'(1));
    step();
    chk("single_issue_early", 64'(sad_valid_out), 64'(0));
    chk("single_pop_count", 64'(fifo_count_out), 64'(0));
    step();
    chk("single_issue", 64'(sad_valid_out), 64'(1));
    chk("single_issue_h", 64'(sad_hcount_out), 64'(0));
    chk("single_issue_v", 64'(sad_vcount_out), 64'(5));
    wait_idle("single");

    // One 20-column row in groups of five; results only from column 12 on
    check_period = 1'b1;
    for (int g = 0; g < 4; g++) begin
      group_strobes = 0;
      for (int k = 0; k < 5; k++) begin
        c = mk_col(g * 5 + k, 0);
        expect_col(c, 1'b1);
        push_col(c);
      end
      wait_idle("row");
    end
    check_period = 1'b0;

    // Burst of 12 into a slow engine: one popped, eight held, three dropped
    eng_lat = 40;
    for (int k = 0; k < 12; k++) begin
      c = mk_col(k, 20);
      if (k < 9) expect_col(c, 1'b1);
      push_col(c);
    end
    chk("burst_drops", 64'(drop_count_out), 64'(3));
    chk("burst_full", 64'(fifo_count_out), 64'(DEPTH));
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (sad_valid_in) seen = 1'b1;
    end
    chk("burst_result_seen", 64'(seen), 64'(1));
    step();
    c = mk_col(100, 20);
    expect_col(c, 1'b1);
    push_col(c);
    chk("full_push_pop_count", 64'(fifo_count_out), 64'(DEPTH));
    chk("full_push_pop_drops", 64'(drop_count_out), 64'(3));
    wait_idle("burst");
    eng_lat = OFF + 2;

    // Silent engine
    eng_mode = 1;
    s0 = strobes;
    c = mk_col(0, 30);
    expect_col(c, 1'b0);
    push_col(c);
    c = mk_col(1, 30);
    expect_col(c, 1'b0);
    push_col(c);
    wait_strobes(s0 + 1, 50, "silent_first_issue");
`ifdef SAD_SCHED_WATCHDOG_EN
    repeat (TMO - 4) step();
    chk("wd_not_yet", 64'(timeout_out), 64'(0));
    chk("wd_still_waiting", 64'(strobes), 64'(s0 + 1));
    wait_strobes(s0 + 2, 100, "wd_next_issue");
    chk("wd_timeout_flag", 64'(timeout_out), 64'(1));
    chk("wd_fifo", 64'(fifo_count_out), 64'(0));
`else
    repeat (3 * TMO) step();
    chk("nowd_timeout", 64'(timeout_out), 64'(0));
    chk("nowd_no_reissue", 64'(strobes), 64'(s0 + 1));
    chk("nowd_fifo", 64'(fifo_count_out), 64'(1));
`endif
    apply_reset("silent_reset");
    eng_mode = 0;

    // Prime a row, then reset while the primed column is in flight; the late result must vanish
    eng_lat = 20;
    for (int k = 0; k < 12; k++) begin
      c = mk_col(k, 40);
      expect_col(c, 1'b1);
      push_col(c);
      wait_idle("preprime");
    end
    s0 = strobes;
    c = mk_col(12, 40);
    expect_col(c, 1'b0);
    push_col(c);
    wait_strobes(s0 + 1, 20, "midwait_issue");
    repeat (5) step();
    apply_reset("midwait_reset");
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (sad_valid_in) seen = 1'b1;
    end
    chk("late_result_seen", 64'(seen), 64'(1));
    repeat (3) step();
    check_all_zero("late_result");

    // Randomized bursts (never more than the FIFO can hold) with random engine latency
    h = 0;
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(8, 1);
      eng_lat = $urandom_range(30, 1);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(15, 0) == 0) h = 0;
        else if (h < 2047) h++;
        c = mk_col(h, $urandom_range(1023, 0));
        expect_col(c, 1'b1);
        push_col(c);
        repeat ($urandom_range(3, 0)) step();
      end
      wait_idle("random");
      chk("random_drops", 64'(drop_count_out), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
